// File: rtl/handshake_pkg.sv
// Shared types for the device B -> device C four-phase word handshake.
package handshake_pkg;

  typedef enum logic {HS_IDLE = 1'b0, HS_ACK = 1'b1} hs_state_t;

  localparam int HS_DATA_W = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read port and an explicit occupancy count.
module sync_fifo
  import handshake_pkg::*;
#(
  parameter int DATA_W = HS_DATA_W,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  // Head word is masked to zero while nothing is buffered, so reset shows rd_data == 0.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_rd    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/device_c_receiver.sv
// Receiver side of the device B word stream: four-phase handshake FSM feeding a FWFT FIFO.
module device_c_receiver
  import handshake_pkg::*;
#(
  parameter int DATA_W = HS_DATA_W,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ready_in,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     accepted_out,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              word_cnt,
  output logic                     proto_err
);

  hs_state_t   state_q, state_d;
  logic        acc_q, acc_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic        wr_en;
  logic        space;

  // A full FIFO still has room if the consumer pops in the same cycle.
  assign space = !full || rd_en;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    err_d      = err_q;
    word_cnt_d = word_cnt_q;
    ready_d    = ready_in;
    wr_en      = 1'b0;
    case (state_q)
      HS_IDLE: begin
        acc_d = 1'b0;
        if (ready_in && space) begin
          wr_en      = 1'b1;
          acc_d      = 1'b1;
          state_d    = HS_ACK;
          word_cnt_d = word_cnt_q + 16'd1;
        end else if (ready_q && !ready_in) begin
          err_d = 1'b1;
        end
      end
      HS_ACK: begin
        if (!ready_in) begin
          acc_d   = 1'b0;
          state_d = HS_IDLE;
        end
      end
      default: begin
        acc_d   = 1'b0;
        state_d = HS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= HS_IDLE;
      acc_q      <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign accepted_out = acc_q;
  assign word_cnt     = word_cnt_q;
  assign proto_err    = err_q;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (data_in),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

endmodule

// File: tb/tb_device_c_receiver.sv
// Bench for device_c_receiver: cycle table for basic handshakes plus scoreboard-checked sequences.
module tb_device_c_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ready_in = 1'b0;
  logic [15:0] data_in = '0;
  logic        rd_en = 1'b0;
  logic        accepted_out;
  logic [15:0] rd_data;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic [15:0] word_cnt;
  logic        proto_err;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] sb[$];

  typedef struct {
    logic        ready;
    logic [15:0] data;
    logic        rd;
    logic        exp_acc;
    logic [3:0]  exp_count;
    logic        exp_empty;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vt[10];

  device_c_receiver #(.DATA_W(16), .DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .ready_in     (ready_in),
    .data_in      (data_in),
    .accepted_out (accepted_out),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .word_cnt     (word_cnt),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One full four-phase handshake; the accepted word goes into the scoreboard.
  task automatic hs(input logic [15:0] d);
    int n;
    n = 0;
    data_in  = d;
    ready_in = 1'b1;
    tick();
    while (!accepted_out && n < 20) begin
      tick();
      n++;
    end
    chk("hs_accept", {31'd0, accepted_out}, 32'd1);
    if (accepted_out) sb.push_back(d);
    ready_in = 1'b0;
    tick();
    chk("hs_rtz", {31'd0, accepted_out}, 32'd0);
  endtask

  task automatic pop_chk();
    logic [15:0] exp;
    exp = sb.pop_front();
    chk("pop_data", {16'd0, rd_data}, {16'd0, exp});
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("pop_count", {28'd0, count}, sb.size());
  endtask

  initial begin
    vt[0] = '{1'b1, 16'hA5C3, 1'b0, 1'b1, 4'd1, 1'b0, 16'hA5C3};
    vt[1] = '{1'b1, 16'hA5C3, 1'b0, 1'b1, 4'd1, 1'b0, 16'hA5C3};
    vt[2] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd1, 1'b0, 16'hA5C3};
    vt[3] = '{1'b0, 16'h0000, 1'b0, 1'b0, 4'd1, 1'b0, 16'hA5C3};
    vt[4] = '{1'b1, 16'h1234, 1'b0, 1'b1, 4'd2, 1'b0, 16'hA5C3};
    vt[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd1, 1'b0, 16'h1234};
    vt[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b1, 16'h0000};
    vt[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b1, 16'h0000};
    vt[8] = '{1'b1, 16'hBEEF, 1'b0, 1'b1, 4'd1, 1'b0, 16'hBEEF};
    vt[9] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b1, 16'h0000};

    // Reset state
    rst = 1'b0;
    tick();
    tick();
    chk("rst_acc", {31'd0, accepted_out}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
    chk("rst_err", {31'd0, proto_err}, 32'd0);
    chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
    rst = 1'b1;
    tick();

    // Cycle table: single word, hold, return to zero, pops, ignored pop at empty
    for (int i = 0; i < 10; i++) begin
      ready_in = vt[i].ready;
      data_in  = vt[i].data;
      rd_en    = vt[i].rd;
      tick();
      chk($sformatf("tbl%0d_acc", i), {31'd0, accepted_out}, {31'd0, vt[i].exp_acc});
      chk($sformatf("tbl%0d_count", i), {28'd0, count}, {28'd0, vt[i].exp_count});
      chk($sformatf("tbl%0d_empty", i), {31'd0, empty}, {31'd0, vt[i].exp_empty});
      chk($sformatf("tbl%0d_rd_data", i), {16'd0, rd_data}, {16'd0, vt[i].exp_rd});
    end
    ready_in = 1'b0;
    rd_en    = 1'b0;
    chk("tbl_word_cnt", {16'd0, word_cnt}, 32'd3);
    chk("tbl_err", {31'd0, proto_err}, 32'd0);

    // Fill to full, back-pressure, then accept on a simultaneous pop
    for (int i = 0; i < 8; i++) hs(16'h3000 + 16'(i));
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_count", {28'd0, count}, 32'd8);
    data_in  = 16'h3008;
    ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_acc_low", {31'd0, accepted_out}, 32'd0);
    end
    chk("bp_count", {28'd0, count}, 32'd8);
    chk("bp_head", {16'd0, rd_data}, {16'd0, sb[0]});
    void'(sb.pop_front());
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("bp_acc_high", {31'd0, accepted_out}, 32'd1);
    chk("bp_count_same", {28'd0, count}, 32'd8);
    chk("bp_full_same", {31'd0, full}, 32'd1);
    sb.push_back(16'h3008);
    ready_in = 1'b0;
    tick();
    chk("bp_rtz", {31'd0, accepted_out}, 32'd0);

    // Withdrawn word while full
    data_in  = 16'hDEAD;
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    tick();
    chk("perr_set", {31'd0, proto_err}, 32'd1);
    chk("perr_count", {28'd0, count}, 32'd8);
    tick();
    tick();
    chk("perr_sticky", {31'd0, proto_err}, 32'd1);
    chk("perr_word_cnt", {16'd0, word_cnt}, 32'd12);
    while (sb.size() > 0) pop_chk();
    chk("drain_empty", {31'd0, empty}, 32'd1);

    // Asynchronous reset between clock edges
    hs(16'h7777);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_acc", {31'd0, accepted_out}, 32'd0);
    chk("arst_empty", {31'd0, empty}, 32'd1);
    chk("arst_count", {28'd0, count}, 32'd0);
    chk("arst_word_cnt", {16'd0, word_cnt}, 32'd0);
    chk("arst_err", {31'd0, proto_err}, 32'd0);
    sb.delete();
    tick();
    rst = 1'b1;
    tick();

    // Ordering across pointer wrap with interleaved pops
    for (int i = 1; i <= 20; i++) begin
      hs(16'(i));
      if (i % 3 == 0) begin
        if (sb.size() > 0) pop_chk();
        if (sb.size() > 0) pop_chk();
      end
      if (i % 5 == 0 && sb.size() > 0) pop_chk();
    end
    chk("order_word_cnt", {16'd0, word_cnt}, 32'd20);
    while (sb.size() > 0) pop_chk();
    chk("order_empty", {31'd0, empty}, 32'd1);
    chk("order_err", {31'd0, proto_err}, 32'd0);

    // Reset while in the acknowledge phase
    data_in  = 16'hABCD;
    ready_in = 1'b1;
    tick();
    chk("abort_acc_up", {31'd0, accepted_out}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_acc", {31'd0, accepted_out}, 32'd0);
    chk("abort_count", {28'd0, count}, 32'd0);
    ready_in = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("abort_idle_acc", {31'd0, accepted_out}, 32'd0);
    chk("abort_idle_err", {31'd0, proto_err}, 32'd0);
    hs(16'h5555);
    chk("abort_recover_count", {28'd0, count}, 32'd1);
    pop_chk();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
